// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared constants for the data-memory arbiter.
//   BE_/ME_ : byte-enable and memory-enable levels driven on the memory port
//   ST_*    : arbiter FSM state encodings
//   REQ_*   : requester IDs used for grants and the last-grant flag
package dm_arbiter_pkg;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic       ME_OFF  = 1'b0;
    localparam logic       ME_ON   = 1'b1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CPU_ACC = 2'd1;
    localparam logic [1:0] ST_DMA_ACC = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    function automatic logic st_is_acc(input logic [1:0] s);
        return (s == ST_CPU_ACC) || (s == ST_DMA_ACC);
    endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// dm_arb_pick: two-way winner selection for the data-memory arbiter.
//   cpu_req, dma_req : pending requests
//   last_gnt         : requester granted most recently (REQ_CPU/REQ_DMA)
//   gnt_id           : winning requester ID
//   gnt_valid        : at least one request pending
// A tie goes to the requester that was not granted last; feeding a constant
// REQ_DMA as last_gnt turns this into fixed CPU priority.
module dm_arb_pick
    import dm_arbiter_pkg::*;
(
    input  logic cpu_req,
    input  logic dma_req,
    input  logic last_gnt,
    output logic gnt_id,
    output logic gnt_valid
);

    assign gnt_valid = cpu_req | dma_req;
    assign gnt_id    = (cpu_req & dma_req) ? ((last_gnt == REQ_CPU) ? REQ_DMA : REQ_CPU)
                                           : (cpu_req ? REQ_CPU : REQ_DMA);

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: arbitrates CPU (M-stage) and DMA/loader accesses onto one data-memory port.
//   clk, reset                : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata/be  : CPU request; cpu_stall, cpu_done, cpu_rdata back to the pipeline
//   dma_req/we/addr/wdata/be  : DMA request; dma_done, dma_rdata back to the loader
//   dm_en/we/addr/wdata/be    : memory command, dm_work while an access is in flight
//   dm_rdata, dm_ready        : memory read data and completion strobe
// Build option: define DM_ARB_RR_EN for round-robin tie breaking; otherwise the
// CPU always wins a tie and no last-grant flag is kept.
module dm_arbiter
    import dm_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_be,
    output logic        dma_done,
    output logic [31:0] dma_rdata,
    output logic        dm_en,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ready,
    output logic        dm_work
);

    logic [1:0]  state_q, state_d;
    logic        win_q, win_d;
    logic        cmd_we_q, cmd_we_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_wdata_q, cmd_wdata_d;
    logic [3:0]  cmd_be_q, cmd_be_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;
    logic        gnt_id, gnt_valid, last_gnt, pick_cpu, acc;

`ifdef DM_ARB_RR_EN
    logic last_q, last_d;

    assign last_gnt = last_q;

    // The flag moves only when an access is actually started.
    always_comb last_d = (state_q == ST_IDLE && gnt_valid) ? gnt_id : last_q;

    always_ff @(posedge clk) begin
        if (reset) last_q <= REQ_DMA;
        else       last_q <= last_d;
    end
`else
    assign last_gnt = REQ_DMA;
`endif

    dm_arb_pick u_pick (
        .cpu_req   (cpu_req),
        .dma_req   (dma_req),
        .last_gnt  (last_gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    assign pick_cpu = gnt_id == REQ_CPU;
    assign acc      = st_is_acc(state_q);

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_be_d    = cmd_be_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            ST_IDLE: if (gnt_valid) begin
                state_d     = pick_cpu ? ST_CPU_ACC : ST_DMA_ACC;
                win_d       = gnt_id;
                cmd_we_d    = pick_cpu ? cpu_we    : dma_we;
                cmd_addr_d  = pick_cpu ? cpu_addr  : dma_addr;
                cmd_wdata_d = pick_cpu ? cpu_wdata : dma_wdata;
                cmd_be_d    = pick_cpu ? cpu_be    : dma_be;
            end
            ST_CPU_ACC, ST_DMA_ACC: if (dm_ready) begin
                state_d     = ST_DONE;
                cpu_rdata_d = (!cmd_we_q && win_q == REQ_CPU) ? dm_rdata : cpu_rdata_q;
                dma_rdata_d = (!cmd_we_q && win_q == REQ_DMA) ? dm_rdata : dma_rdata_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            win_q       <= REQ_CPU;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= 32'h0;
            cmd_wdata_q <= 32'h0;
            cmd_be_q    <= BE_NONE;
            cpu_rdata_q <= 32'h0;
            dma_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_be_q    <= cmd_be_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign dm_en     = acc ? ME_ON : ME_OFF;
    assign dm_work   = acc;
    assign dm_we     = acc & cmd_we_q;
    assign dm_be     = acc ? cmd_be_q : BE_NONE;
    assign dm_addr   = cmd_addr_q;
    assign dm_wdata  = cmd_wdata_q;
    assign cpu_done  = (state_q == ST_DONE) && (win_q == REQ_CPU);
    assign dma_done  = (state_q == ST_DONE) && (win_q == REQ_DMA);
    // Dropping the stall in the done cycle lets the stage advance on that edge.
    assign cpu_stall = cpu_req & ~cpu_done;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed scenarios plus a randomized run against a cycle-timeline reference model.
module tb_dm_arbiter;

    localparam bit T_CPU = 1'b0;
    localparam bit T_DMA = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we, dm_ready;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, dm_rdata;
    logic [3:0]  cpu_be, dma_be;
    logic        cpu_stall, cpu_done, dma_done, dm_en, dm_we, dm_work;
    logic [31:0] cpu_rdata, dma_rdata, dm_addr, dm_wdata;
    logic [3:0]  dm_be;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    int          cyc = 0;
    bit          m_acc = 1'b0;
    int          m_start = 0;
    int          m_free = 0;
    int          m_done_cyc = -10;
    bit          m_done_who = T_CPU;
    bit          m_who = T_CPU;
    bit          m_last = T_DMA;
    bit          m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rd [2];
    bit          pend [2];

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_be    (cpu_be),
        .cpu_stall (cpu_stall),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_be    (dma_be),
        .dma_done  (dma_done),
        .dma_rdata (dma_rdata),
        .dm_en     (dm_en),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .dm_work   (dm_work)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit pick(input bit c_req, input bit d_req);
        if (c_req && d_req) begin
`ifdef DM_ARB_RR_EN
            return (m_last == T_CPU) ? T_DMA : T_CPU;
`else
            return T_CPU;
`endif
        end
        return c_req ? T_CPU : T_DMA;
    endfunction

    task automatic new_fields(input bit r);
        if (r == T_CPU) begin
            cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom; cpu_be = 4'($urandom);
        end else begin
            dma_we = 1'($urandom); dma_addr = $urandom; dma_wdata = $urandom; dma_be = 4'($urandom);
        end
    endtask

    // Timeline model: a grant in a free cycle starts the access next cycle,
    // a dm_ready cycle gives done next cycle and a free arbiter the cycle after.
    task automatic run_random(input int ncyc, input int pct);
        for (int k = 0; k < ncyc; k++) begin
            bit exp_en, ecd, edd;
            tick();
            cyc++;
            for (int r = 0; r < 2; r++) begin
                if (pend[r] && m_done_cyc == cyc - 1 && m_done_who == 1'(r)) pend[r] = 1'b0;
                if (!pend[r] && $urandom_range(99) < pct) begin
                    pend[r] = 1'b1;
                    new_fields(1'(r));
                end else if (m_acc && m_who == 1'(r)) new_fields(1'(r));
                else if (!pend[r]) new_fields(1'(r));
            end
            cpu_req = pend[0];
            dma_req = pend[1];
            exp_en = m_acc && cyc >= m_start;
            dm_ready = exp_en ? ($urandom_range(2) == 0) : 1'($urandom_range(1));
            dm_rdata = $urandom;
            #1;
            ecd = m_done_cyc == cyc && m_done_who == T_CPU;
            edd = m_done_cyc == cyc && m_done_who == T_DMA;
            chk("rnd_en", dm_en, exp_en);
            chk("rnd_work", dm_work, exp_en);
            chk("rnd_we", dm_we, exp_en & m_we);
            chk("rnd_be", dm_be, exp_en ? m_be : 4'h0);
            if (exp_en) begin
                chk("rnd_addr", dm_addr, m_addr);
                chk("rnd_wdata", dm_wdata, m_wdata);
            end
            chk("rnd_cpu_done", cpu_done, ecd);
            chk("rnd_dma_done", dma_done, edd);
            chk("rnd_cpu_rdata", cpu_rdata, m_rd[0]);
            chk("rnd_dma_rdata", dma_rdata, m_rd[1]);
            chk("rnd_stall", cpu_stall, cpu_req & ~ecd);
            if (exp_en && dm_ready) begin
                if (!m_we) m_rd[m_who] = dm_rdata;
                m_done_cyc = cyc + 1;
                m_done_who = m_who;
                m_acc = 1'b0;
                m_free = cyc + 2;
            end else if (!m_acc && cyc >= m_free && (pend[0] || pend[1])) begin
                m_who = pick(pend[0], pend[1]);
                m_we = (m_who == T_CPU) ? cpu_we : dma_we;
                m_addr = (m_who == T_CPU) ? cpu_addr : dma_addr;
                m_wdata = (m_who == T_CPU) ? cpu_wdata : dma_wdata;
                m_be = (m_who == T_CPU) ? cpu_be : dma_be;
                m_acc = 1'b1;
                m_start = cyc + 1;
                m_last = m_who;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_be = 0;
        dm_ready = 0; dm_rdata = 0;
        tick();
        tick();
        chk("rst_en", dm_en, 0);
        chk("rst_work", dm_work, 0);
        chk("rst_we", dm_we, 0);
        chk("rst_be", dm_be, 0);
        chk("rst_cpu_done", cpu_done, 0);
        chk("rst_dma_done", dma_done, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        chk("rst_addr", dm_addr, 0);
        chk("rst_wdata", dm_wdata, 0);
        cpu_req = 1; #1;
        chk("rst_stall_hi", cpu_stall, 1);
        cpu_req = 0; #1;
        chk("rst_stall_lo", cpu_stall, 0);
        reset = 1'b0;

        // CPU load, memory ready on the first enable cycle
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0010; cpu_be = 4'hF; #1;
        chk("a_stall_n", cpu_stall, 1);
        chk("a_en_n", dm_en, 0);
        tick();
        chk("a_en", dm_en, 1);
        chk("a_addr", dm_addr, 32'h0000_0010);
        chk("a_we", dm_we, 0);
        chk("a_stall_n1", cpu_stall, 1);
        dm_ready = 1; dm_rdata = 32'hDEAD_BEEF;
        tick();
        chk("a_done", cpu_done, 1);
        chk("a_stall_n2", cpu_stall, 0);
        chk("a_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("a_en_off", dm_en, 0);
        cpu_req = 0; dm_ready = 0; dm_rdata = 0;
        tick();
        chk("a_done_off", cpu_done, 0);

        // CPU store with three wait states; inputs scrambled mid-access
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_0100; cpu_wdata = 32'hCAFE_F00D; cpu_be = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b_en", dm_en, 1);
            chk("b_we", dm_we, 1);
            chk("b_addr", dm_addr, 32'h0000_0100);
            chk("b_wdata", dm_wdata, 32'hCAFE_F00D);
            chk("b_be", dm_be, 4'b0011);
            chk("b_stall", cpu_stall, 1);
            chk("b_done_early", cpu_done, 0);
            if (i == 0) begin
                cpu_addr = $urandom; cpu_wdata = $urandom; cpu_be = 4'($urandom); cpu_we = 0;
            end
            if (i == 3) begin
                dm_ready = 1; dm_rdata = 32'h0BAD_0BAD;
            end
        end
        tick();
        chk("b_done", cpu_done, 1);
        chk("b_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
        cpu_req = 0; dm_ready = 0;

        // DMA in flight, CPU request arrives mid-access
        tick();
        dma_req = 1; dma_we = 0; dma_addr = 32'h0000_0020; dma_be = 4'hF;
        tick();
        chk("c_en", dm_en, 1);
        chk("c_addr", dm_addr, 32'h0000_0020);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0030; cpu_be = 4'hF; #1;
        chk("c_stall1", cpu_stall, 1);
        tick();
        chk("c_addr2", dm_addr, 32'h0000_0020);
        chk("c_stall2", cpu_stall, 1);
        dm_ready = 1; dm_rdata = 32'h1234_5678;
        tick();
        chk("c_dma_done", dma_done, 1);
        chk("c_cpu_done", cpu_done, 0);
        chk("c_stall3", cpu_stall, 1);
        chk("c_dma_rdata", dma_rdata, 32'h1234_5678);
        chk("c_en_done", dm_en, 0);
        dma_req = 0; dm_ready = 0;
        tick();
        chk("c_en_idle", dm_en, 0);
        chk("c_stall4", cpu_stall, 1);
        chk("c_dma_done_off", dma_done, 0);
        tick();
        chk("c_cpu_en", dm_en, 1);
        chk("c_cpu_addr", dm_addr, 32'h0000_0030);
        chk("c_stall5", cpu_stall, 1);
        dm_ready = 1; dm_rdata = 32'h5555_AAAA;
        tick();
        chk("c_cpu_done2", cpu_done, 1);
        chk("c_stall6", cpu_stall, 0);
        chk("c_cpu_rdata", cpu_rdata, 32'h5555_AAAA);
        chk("c_dma_rdata_kept", dma_rdata, 32'h1234_5678);
        cpu_req = 0; dm_ready = 0;

        // DMA store, request dropped mid-access
        tick();
        dma_req = 1; dma_we = 1; dma_addr = 32'h0000_0040; dma_wdata = 32'h4040_4040; dma_be = 4'b1100;
        tick();
        chk("d_en", dm_en, 1);
        chk("d_we", dm_we, 1);
        chk("d_addr", dm_addr, 32'h0000_0040);
        dma_req = 0; dma_addr = $urandom;
        tick();
        chk("d_addr2", dm_addr, 32'h0000_0040);
        chk("d_be", dm_be, 4'b1100);
        dm_ready = 1;
        tick();
        chk("d_done", dma_done, 1);
        chk("d_rdata_kept", dma_rdata, 32'h1234_5678);
        dm_ready = 0;
        tick();
        chk("d_done_off", dma_done, 0);
        chk("d_en_off", dm_en, 0);
        tick();
        chk("d_no_regrant", dm_en, 0);

        // Reset in DMA_ACC with dm_ready in the same cycle
        dma_req = 1; dma_we = 0; dma_addr = 32'h0000_0050;
        tick();
        chk("e_en", dm_en, 1);
        chk("e_addr", dm_addr, 32'h0000_0050);
        reset = 1; dm_ready = 1; dm_rdata = 32'hFFFF_FFFF; dma_req = 0;
        tick();
        chk("e_dma_done", dma_done, 0);
        chk("e_en", dm_en, 0);
        chk("e_work", dm_work, 0);
        chk("e_we", dm_we, 0);
        chk("e_be", dm_be, 0);
        chk("e_addr0", dm_addr, 0);
        chk("e_wdata0", dm_wdata, 0);
        chk("e_cpu_rdata", cpu_rdata, 0);
        chk("e_dma_rdata", dma_rdata, 0);
        reset = 0; dm_ready = 0;
        tick();
        chk("e_dma_done2", dma_done, 0);
        chk("e_en2", dm_en, 0);

        // Simultaneous requests right after reset: CPU first, then DMA
        cpu_req = 1; dma_req = 1; cpu_we = 1; cpu_addr = 32'h0000_0060; dma_we = 1; dma_addr = 32'h0000_0070;
        dm_ready = 1;
        tick();
        chk("f_en1", dm_en, 1);
        chk("f_addr1", dm_addr, 32'h0000_0060);
        tick();
        chk("f_cpu_done", cpu_done, 1);
        chk("f_dma_done0", dma_done, 0);
        cpu_req = 0;
        tick();
        chk("f_idle", dm_en, 0);
        tick();
        chk("f_en2", dm_en, 1);
        chk("f_addr2", dm_addr, 32'h0000_0070);
        tick();
        chk("f_dma_done", dma_done, 1);
        dma_req = 0; dm_ready = 0;

        m_rd[0] = 32'h0;
        m_rd[1] = 32'h0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        m_last = T_DMA;
        run_random(400, 30);
        run_random(150, 100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: cpu_req  in  1  M-stage memory access request (load or store to the memory device).
REQ-004 SHALL have ports: cpu_we  in  1  1=store; cpu_addr  in  32; cpu_wdata  in  32; cpu_be  in  4  byte enables.
REQ-005 SHALL have ports: cpu_stall  out  1  freeze pipeline; cpu_done  out  1  one-cycle completion pulse; cpu_rdata  out  32  load data.
REQ-006 SHALL have ports: dma_req  in  1; dma_we  in  1; dma_addr  in  32; dma_wdata  in  32; dma_be  in  4  (second requester, loader/DMA).
REQ-007 SHALL have ports: dma_done  out  1  one-cycle pulse; dma_rdata  out  32.
REQ-008 SHALL have ports: dm_en  out  1; dm_we  out  1; dm_addr  out  32; dm_wdata  out  32; dm_be  out  4  (data memory port).
REQ-009 SHALL have ports: dm_rdata  in  32; dm_ready  in  1  memory completes access this cycle; dm_work  out  1  access in flight.

Function
REQ-010 SHALL implement FSM states IDLE, CPU_ACC, DMA_ACC, DONE.
REQ-011 IDLE: when any request is pending, SHALL pick a winner per REQ-017/REQ-024, latch its we/addr/wdata/be into command registers, and enter CPU_ACC or DMA_ACC on the next edge.
REQ-012 CPU_ACC/DMA_ACC: SHALL drive dm_en=1, dm_work=1, and dm_we/dm_addr/dm_wdata/dm_be from the command registers; SHALL hold these until dm_ready=1.
REQ-013 On dm_ready=1 in an ACC state, SHALL register dm_rdata into the winner's rdata register (loads only; stores leave it unchanged) and enter DONE.
REQ-014 DONE: SHALL assert the winner's done pulse for exactly one cycle, grant no requester, and return to IDLE.
REQ-015 Latency: a request seen in IDLE at cycle N with dm_ready=1 at N+1 SHALL give done=1 at N+2 and IDLE at N+3; each extra cycle with dm_ready=0 adds one cycle.
REQ-016 cpu_stall SHALL equal cpu_req AND NOT cpu_done (combinational), so the stage advances in the done cycle.
REQ-017 Default priority: fixed; CPU wins a simultaneous request in IDLE.
REQ-018 Requester inputs changing or dropping during ACC SHALL NOT affect the in-flight access; the access completes and done is still pulsed.
REQ-019 dm_en, dm_we, dm_be SHALL be 0 outside ACC states; dm_ready outside ACC states SHALL be ignored.
REQ-020 rdata outputs SHALL hold their last loaded value until the next load completion for that requester.

Reset
REQ-021 With reset=1 at a clock edge: state=IDLE; cpu_done, dma_done, dm_en, dm_we, dm_work=0; dm_be=0; command registers, cpu_rdata, dma_rdata = 32'h0; last-grant flag = DMA.
REQ-022 Reset during an ACC state SHALL abandon the access with no done pulse; the pending dm_ready is ignored.
REQ-023 cpu_stall after reset SHALL follow REQ-016 (high if cpu_req is high).

Configuration
REQ-024 Macro DM_ARB_RR_EN defined: round-robin; on simultaneous requests in IDLE the requester not granted last wins; the last-grant flag updates on entry to an ACC state. Undefined: fixed CPU priority (REQ-017), flag logic absent.

Structure
REQ-025 FSM state encodings and the requester IDs SHALL be defined in the shared public header alongside the existing BE_/ME_ constants.
REQ-026 Winner selection SHALL live in one sub-module dm_arb_pick (inputs: two requests, last-grant flag; output: grant ID, valid).

Verification
REQ-027 CPU load only: cpu_req=1, cpu_we=0, addr 32'h0000_0010, dm_ready=1 at first dm_en cycle, dm_rdata=32'hDEAD_BEEF -> cpu_done at N+2, cpu_rdata=32'hDEAD_BEEF, cpu_stall high N..N+1, low N+2.
REQ-028 Wait states: CPU store, be=4'b0011, dm_ready low 3 cycles -> dm_en high 4 cycles with stable addr/wdata/be, cpu_done at N+5, cpu_rdata unchanged.
REQ-029 Simultaneous cpu_req and dma_req held, both auto-advancing -> fixed build: CPU,DMA order; with DM_ARB_RR_EN after reset: CPU,DMA,CPU,DMA alternating.
REQ-030 DMA in flight, cpu_req rises mid-access -> DMA completes with dma_done; CPU granted in the IDLE after DONE; cpu_stall high throughout.
REQ-031 Reset asserted in DMA_ACC with dm_ready=1 same cycle -> no dma_done, all outputs at reset values next cycle.
REQ-032 dma_req dropped mid-access -> access completes, dma_done still pulses once.
